// File: rtl/traffic_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_ctrl
//   Highway / farm-road traffic light controller. It starts the paired
//   interval timer with a one-cycle `sc` pulse on every state entry, checks
//   the timer's registered echo `fb`, and walks the lamps through
//   HG -> HY -> FG -> FY -> HG driven by the synchronized car sensor.
//   Any break in the sc/fb handshake parks the controller in FAULT
//   (both heads red) until reset.
//
// Parameters
//   SYNC_STAGES : flops on the asynchronous car sensor input (must be >= 2)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset
//   c     in   farm-road car present (asynchronous to clk)
//   tl    in   timer long timeout (count 29, saturating)
//   ts    in   timer short timeout (count 2, single cycle)
//   fb    in   timer start echo (registered copy of sc)
//   sc    out  start-count pulse to the timer
//   hl    out  highway lamp  (00 green, 01 yellow, 10 red)
//   fl    out  farm lamp     (same encoding)
//   fault out  handshake fault, sticky until reset
// -----------------------------------------------------------------------------
module traffic_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c,
    input  logic       tl,
    input  logic       ts,
    input  logic       fb,
    output logic       sc,
    output logic [1:0] hl,
    output logic [1:0] fl,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_HG    = 3'd0,
        S_HY    = 3'd1,
        S_FG    = 3'd2,
        S_FY    = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b01;
    localparam logic [1:0] LAMP_R = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic                   sc_q, sc_d;
    logic                   sc_dly_q, sc_dly_d;   // sc delayed one cycle: what fb must equal
    logic                   armed_q, armed_d;
    logic                   fault_q, fault_d;
    logic [1:0]             hl_q, hl_d;
    logic [1:0]             fl_q, fl_d;

    logic c_s;
    logic tl_a;
    logic ts_a;
    logic hs_err;

    // Car sensor synchronizer: shift in at bit 0, use the oldest bit.
    assign c_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], c};
    end

    // ------------------------------------------------------------------
    // Next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sc_d     = 1'b0;
        sc_dly_d = sc_q;
        armed_d  = armed_q;
        fault_d  = fault_q;
        hl_d     = hl_q;
        fl_d     = fl_q;

        // Timeout flags are only trusted once the timer has echoed the
        // latest start; before that they may still describe the previous
        // interval.
        tl_a   = armed_q & tl;
        ts_a   = armed_q & ts;
        hs_err = (fb != sc_dly_q);

        if (state_q != S_FAULT) begin
            if (hs_err) begin
                state_d = S_FAULT;
            end else begin
                case (state_q)
                    S_HG:    if (c_s && tl_a)  state_d = S_HY;
                    S_HY:    if (ts_a)         state_d = S_FG;
                    S_FG:    if (!c_s || tl_a) state_d = S_FY;
                    S_FY:    if (ts_a)         state_d = S_HG;
                    default:                   state_d = S_FAULT;
                endcase
            end
        end

        // One start pulse on the first cycle of every normal state.
        sc_d = (state_d != state_q) && (state_d != S_FAULT);

        // Disarm on a new start; re-arm once the echo lines up with it.
        if (sc_d)
            armed_d = 1'b0;
        else if (fb && sc_dly_q)
            armed_d = 1'b1;

        fault_d = (state_d == S_FAULT);

        // Lamps decode the next state so they switch on the same edge.
        case (state_d)
            S_HG:    begin hl_d = LAMP_G; fl_d = LAMP_R; end
            S_HY:    begin hl_d = LAMP_Y; fl_d = LAMP_R; end
            S_FG:    begin hl_d = LAMP_R; fl_d = LAMP_G; end
            S_FY:    begin hl_d = LAMP_R; fl_d = LAMP_Y; end
            default: begin hl_d = LAMP_R; fl_d = LAMP_R; end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset looks like a fresh HG entry: sc is already high so
    // the timer restarts on the first edge after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            state_q  <= S_HG;
            sc_q     <= 1'b1;
            sc_dly_q <= 1'b0;
            armed_q  <= 1'b0;
            fault_q  <= 1'b0;
            hl_q     <= LAMP_G;
            fl_q     <= LAMP_R;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            sc_q     <= sc_d;
            sc_dly_q <= sc_dly_d;
            armed_q  <= armed_d;
            fault_q  <= fault_d;
            hl_q     <= hl_d;
            fl_q     <= fl_d;
        end
    end

    assign sc    = sc_q;
    assign hl    = hl_q;
    assign fl    = fl_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_ctrl
//   Bench for traffic_ctrl with a behavioural interval timer attached.
//   Expected state entries (edge number + lamps) are queued per scenario and
//   popped whenever the controller raises sc.
// -----------------------------------------------------------------------------
module tb_traffic_ctrl;

    localparam int SYNC = 2;
    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       c   = 1'b0;
    logic       tl, ts, fb, sc, fault;
    logic [1:0] hl, fl;

    // timer model and overrides
    logic [4:0] cnt;
    logic       fb_t;
    logic       fb_ov_en   = 1'b0;
    logic       fb_ov      = 1'b0;
    logic       flag_ov_en = 1'b0;

    int cyc;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         edge_n;
        logic [1:0] hl;
        logic [1:0] fl;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [1:0] cur_hl, cur_fl;

    traffic_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst   (rst),
        .c     (c),
        .tl    (tl),
        .ts    (ts),
        .fb    (fb),
        .sc    (sc),
        .hl    (hl),
        .fl    (fl),
        .fault (fault)
    );

    always #5 clk = ~clk;

    // Interval timer: restarts on sc, echoes sc, saturates at 29.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= 5'd0;
            fb_t <= 1'b0;
        end else begin
            fb_t <= sc;
            if (sc)
                cnt <= 5'd0;
            else if (cnt != 5'd29)
                cnt <= cnt + 5'd1;
        end
    end

    assign fb = fb_ov_en   ? fb_ov : fb_t;
    assign ts = flag_ov_en ? 1'b1  : (cnt == 5'd2);
    assign tl = flag_ov_en ? 1'b1  : (cnt == 5'd29);

    // Edge counter: value n at the negedge following edge n after release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic push(input int edge_n, input logic [1:0] h, input logic [1:0] f);
        exp_t x;
        x.edge_n = edge_n;
        x.hl     = h;
        x.fl     = f;
        sb.push_back(x);
    endtask

    // Holds reset for 3 cycles and releases it on a negedge (cyc == 0).
    task automatic apply_reset(input logic car);
        @(negedge clk);
        rst        = 1'b0;
        c          = car;
        fb_ov_en   = 1'b0;
        flag_ov_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        c   = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (hl !== G || fl !== R) begin
            n_fail++;
            $display("FAIL reset_lamps: hl=%b fl=%b, expected hl=%b fl=%b", hl, fl, G, R);
        end
        n_chk++;
        if (sc !== 1'b1 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sc_fault: sc=%b fault=%b, expected sc=1 fault=0", sc, fault);
        end
        rst = 1'b1;
        sb.delete();
        push(0, G, R);
        while (cyc < 200) begin
            if (sc === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL reset_idle_sc: sc at edge %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.edge_n || hl !== e.hl || fl !== e.fl) begin
                        n_fail++;
                        $display("FAIL reset_entry: edge %0d hl=%b fl=%b, expected edge %0d hl=%b fl=%b",
                                 cyc, hl, fl, e.edge_n, e.hl, e.fl);
                    end
                    cur_hl = e.hl;
                    cur_fl = e.fl;
                end
            end
            n_chk++;
            if (hl !== cur_hl || fl !== cur_fl || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: edge %0d hl=%b fl=%b fault=%b, expected hl=%b fl=%b fault=0",
                         cyc, hl, fl, fault, cur_hl, cur_fl);
            end
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_missing: %0d entries not seen, expected 0", sb.size());
        end
    endtask

    // Continues from test_reset: car arrives long after the HG minimum.
    task automatic test_late_car();
        sb.delete();
        push(200 + SYNC + 1, Y, R);
        push(200 + SYNC + 5, R, G);
        c = 1'b1;
        while (cyc < 216) begin
            if (sc === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL late_car_sc: sc at edge %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.edge_n || hl !== e.hl || fl !== e.fl) begin
                        n_fail++;
                        $display("FAIL late_car_entry: edge %0d hl=%b fl=%b, expected edge %0d hl=%b fl=%b",
                                 cyc, hl, fl, e.edge_n, e.hl, e.fl);
                    end
                    cur_hl = e.hl;
                    cur_fl = e.fl;
                end
            end
            n_chk++;
            if (hl !== cur_hl || fl !== cur_fl || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL late_car_lamps: edge %0d hl=%b fl=%b fault=%b, expected hl=%b fl=%b fault=0",
                         cyc, hl, fl, fault, cur_hl, cur_fl);
            end
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL late_car_missing: %0d entries not seen, expected 0", sb.size());
        end
    endtask

    // Car present throughout: full cycle on timeouts.
    task automatic test_car_held(input bit do_rst);
        if (do_rst) apply_reset(1'b1);
        sb.delete();
        push(0, G, R);
        push(31, Y, R);
        push(35, R, G);
        push(66, R, Y);
        push(70, G, R);
        while (cyc < 76) begin
            if (sc === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL car_held_sc: sc at edge %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.edge_n || hl !== e.hl || fl !== e.fl) begin
                        n_fail++;
                        $display("FAIL car_held_entry: edge %0d hl=%b fl=%b, expected edge %0d hl=%b fl=%b",
                                 cyc, hl, fl, e.edge_n, e.hl, e.fl);
                    end
                    cur_hl = e.hl;
                    cur_fl = e.fl;
                end
            end
            n_chk++;
            if (hl !== cur_hl || fl !== cur_fl || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL car_held_lamps: edge %0d hl=%b fl=%b fault=%b, expected hl=%b fl=%b fault=0",
                         cyc, hl, fl, fault, cur_hl, cur_fl);
            end
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL car_held_missing: %0d entries not seen, expected 0", sb.size());
        end
    endtask

    // Car leaves during FG (FG entered at edge 35). Departure late enough to
    // coincide with tl must still give exactly one FY entry.
    task automatic test_car_leaves(input int drop);
        int fy;
        fy = (drop + SYNC + 1 < 66) ? drop + SYNC + 1 : 66;
        apply_reset(1'b1);
        sb.delete();
        push(0, G, R);
        push(31, Y, R);
        push(35, R, G);
        push(fy, R, Y);
        push(fy + 4, G, R);
        while (cyc < fy + 14) begin
            if (sc === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL car_leaves_sc(%0d): sc at edge %0d, expected none", drop, cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.edge_n || hl !== e.hl || fl !== e.fl) begin
                        n_fail++;
                        $display("FAIL car_leaves_entry(%0d): edge %0d hl=%b fl=%b, expected edge %0d hl=%b fl=%b",
                                 drop, cyc, hl, fl, e.edge_n, e.hl, e.fl);
                    end
                    cur_hl = e.hl;
                    cur_fl = e.fl;
                end
            end
            n_chk++;
            if (hl !== cur_hl || fl !== cur_fl || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL car_leaves_lamps(%0d): edge %0d hl=%b fl=%b fault=%b, expected hl=%b fl=%b fault=0",
                         drop, cyc, hl, fl, fault, cur_hl, cur_fl);
            end
            if (cyc == drop) c = 1'b0;
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL car_leaves_missing(%0d): %0d entries not seen, expected 0", drop, sb.size());
        end
    endtask

    // Both flags forced high over the sc and echo cycles of HY entry.
    task automatic test_stale_mask();
        apply_reset(1'b1);
        sb.delete();
        push(0, G, R);
        push(31, Y, R);
        push(35, R, G);
        while (cyc < 42) begin
            if (sc === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL stale_sc: sc at edge %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.edge_n || hl !== e.hl || fl !== e.fl) begin
                        n_fail++;
                        $display("FAIL stale_entry: edge %0d hl=%b fl=%b, expected edge %0d hl=%b fl=%b",
                                 cyc, hl, fl, e.edge_n, e.hl, e.fl);
                    end
                    cur_hl = e.hl;
                    cur_fl = e.fl;
                end
            end
            n_chk++;
            if (hl !== cur_hl || fl !== cur_fl || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_lamps: edge %0d hl=%b fl=%b fault=%b, expected hl=%b fl=%b fault=0",
                         cyc, hl, fl, fault, cur_hl, cur_fl);
            end
            if (cyc == 31) flag_ov_en = 1'b1;
            if (cyc == 33) flag_ov_en = 1'b0;
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL stale_missing: %0d entries not seen, expected 0", sb.size());
        end
    endtask

    // Echo suppressed from the HY transition (sc at edge 31).
    task automatic test_fault_no_echo();
        logic [1:0] eh, ef;
        logic       esc, efa;
        apply_reset(1'b1);
        while (cyc < 80) begin
            esc = (cyc == 0 || cyc == 31);
            if (cyc < 31)      begin eh = G; ef = R; efa = 1'b0; end
            else if (cyc < 33) begin eh = Y; ef = R; efa = 1'b0; end
            else               begin eh = R; ef = R; efa = 1'b1; end
            n_chk++;
            if (hl !== eh || fl !== ef || sc !== esc || fault !== efa) begin
                n_fail++;
                $display("FAIL no_echo: edge %0d hl=%b fl=%b sc=%b fault=%b, expected hl=%b fl=%b sc=%b fault=%b",
                         cyc, hl, fl, sc, fault, eh, ef, esc, efa);
            end
            if (cyc == 30) begin fb_ov_en = 1'b1; fb_ov = 1'b0; end
            if (cyc == 50) fb_ov = 1'b1;
            if (cyc == 51) begin fb_ov = 1'b0; c = 1'b0; end
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (fault !== 1'b0 || hl !== G || fl !== R || sc !== 1'b1) begin
            n_fail++;
            $display("FAIL no_echo_clear: hl=%b fl=%b sc=%b fault=%b, expected hl=00 fl=10 sc=1 fault=0",
                     hl, fl, sc, fault);
        end
    endtask

    // Echo with no preceding start, while idling in HG.
    task automatic test_fault_spurious();
        logic [1:0] eh, ef;
        logic       esc, efa;
        apply_reset(1'b0);
        while (cyc < 40) begin
            esc = (cyc == 0);
            if (cyc <= 10) begin eh = G; ef = R; efa = 1'b0; end
            else           begin eh = R; ef = R; efa = 1'b1; end
            n_chk++;
            if (hl !== eh || fl !== ef || sc !== esc || fault !== efa) begin
                n_fail++;
                $display("FAIL spurious: edge %0d hl=%b fl=%b sc=%b fault=%b, expected hl=%b fl=%b sc=%b fault=%b",
                         cyc, hl, fl, sc, fault, eh, ef, esc, efa);
            end
            if (cyc == 10) begin fb_ov_en = 1'b1; fb_ov = 1'b1; end
            if (cyc == 11) fb_ov_en = 1'b0;
            if (cyc == 20) c = 1'b1;
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (fault !== 1'b0 || hl !== G || fl !== R || sc !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_clear: hl=%b fl=%b sc=%b fault=%b, expected hl=00 fl=10 sc=1 fault=0",
                     hl, fl, sc, fault);
        end
    endtask

    // Reset pulled mid-FG; outputs must respond without a clock edge.
    task automatic test_reset_mid();
        apply_reset(1'b1);
        while (cyc < 40) @(negedge clk);
        n_chk++;
        if (hl !== R || fl !== G) begin
            n_fail++;
            $display("FAIL mid_pre: hl=%b fl=%b, expected hl=10 fl=00", hl, fl);
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (hl !== G || fl !== R || sc !== 1'b1 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: hl=%b fl=%b sc=%b fault=%b, expected hl=00 fl=10 sc=1 fault=0",
                     hl, fl, sc, fault);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_car_held(1'b0);
    endtask

    initial begin
        test_reset();
        test_late_car();
        test_car_held(1'b1);
        test_car_leaves(45);
        test_car_leaves(63);
        test_stale_mask();
        test_fault_no_echo();
        test_fault_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t reached, expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
